// File: rtl/scaler_pkg.sv
// scaler_pkg: scale-mode encodings and sequencer states shared by the scaler control block
package scaler_pkg;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_FIT     = 2'd1,
    MODE_STRETCH = 2'd2
  } scale_mode_e;
  typedef enum logic [2:0] {
    IDLE,
    H_REQ,
    H_WAIT,
    V_REQ,
    V_WAIT,
    CENTRE,
    DONE
  } state_e;
endpackage

// File: rtl/scaler_axis_req.sv
// scaler_axis_req: one interpolator handshake (request pulse, ready latch, timeout) plus centring offset
module scaler_axis_req #(
  parameter int bitwidth = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                calc_i,
  input  logic                ready_i,
  input  logic [bitwidth-1:0] limit_out_i,
  input  logic [bitwidth-1:0] out_i,
  output logic                newfraction_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [bitwidth-1:0] centre_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic                wait_q, nf_q, done_q, to_q;
  logic [TW-1:0]       tmr_q;
  logic [bitwidth-1:0] lim_q, ctr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wait_q <= 1'b0;
      nf_q   <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
      tmr_q  <= '0;
      lim_q  <= '0;
      ctr_q  <= '0;
    end else begin
      nf_q   <= start_i;
      done_q <= 1'b0;
      to_q   <= 1'b0;
      if (start_i) begin
        wait_q <= 1'b1;
        tmr_q  <= '0;
      end else if (wait_q) begin
        if (ready_i) begin
          wait_q <= 1'b0;
          done_q <= 1'b1;
          lim_q  <= limit_out_i;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          wait_q <= 1'b0;
          to_q   <= 1'b1;
        end else tmr_q <= tmr_q + TW'(1);
      end
      if (calc_i) ctr_q <= lim_q < out_i ? (out_i - lim_q) >> 1 : '0;
    end
  assign newfraction_o = nf_q;
  assign done_o        = done_q;
  assign timeout_o     = to_q;
  assign centre_o      = ctr_q;
endmodule

// File: rtl/scaler_ctrl.sv
// scaler_ctrl: waits for a stable source size, then configures the H and V interpolators and centres the result
module scaler_ctrl
  import scaler_pkg::*;
#(
  parameter int bitwidth      = 10,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [bitwidth-1:0] in_width,
  input  logic [bitwidth-1:0] in_height,
  input  logic [bitwidth-1:0] out_width,
  input  logic [bitwidth-1:0] out_height,
  input  logic [1:0]          scale_mode,
  output logic [bitwidth-1:0] h_num,
  output logic [bitwidth-1:0] h_den,
  output logic [bitwidth-1:0] h_limit,
  output logic                h_newfraction,
  input  logic                h_ready,
  input  logic [bitwidth-1:0] h_limit_out,
  output logic [bitwidth-1:0] h_centre_offset,
  output logic [bitwidth-1:0] v_num,
  output logic [bitwidth-1:0] v_den,
  output logic [bitwidth-1:0] v_limit,
  output logic                v_newfraction,
  input  logic                v_ready,
  input  logic [bitwidth-1:0] v_limit_out,
  output logic [bitwidth-1:0] v_centre_offset,
  output logic                cfg_busy,
  output logic                cfg_valid,
  output logic                cfg_error
);
  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [bitwidth-1:0] ONE = bitwidth'(1);
  state_e                state_q;
  logic [bitwidth-1:0]   in_w_q, in_h_q, out_w_q, out_h_q;
  logic [1:0]            mode_q;
  logic [CW-1:0]         cnt_q;
  logic                  applied_q, busy_q, valid_q, error_q;
  logic [bitwidth-1:0]   h_num_q, h_den_q, h_lim_q, v_num_q, v_den_q, v_lim_q;
  logic                  meas_chg, chg, stable, start, fit_w;
  logic [2*bitwidth-1:0] xw, xh;
  logic [bitwidth-1:0]   fit_n, fit_d, h_num_d, h_den_d, v_num_d, v_den_d;
  logic                  h_done, h_to, v_done, v_to;
  assign meas_chg = in_valid && (in_width != in_w_q || in_height != in_h_q);
  assign chg      = meas_chg || scale_mode != mode_q || out_width != out_w_q || out_height != out_h_q;
  assign stable   = cnt_q >= CW'(STABLE_FRAMES);
  assign start    = state_q == IDLE && stable && !applied_q && in_w_q != '0 && in_h_q != '0;
  // Fit picks the limiting axis: out_w/in_w <= out_h/in_h without dividing
  assign xw      = (2*bitwidth)'(out_w_q) * (2*bitwidth)'(in_h_q);
  assign xh      = (2*bitwidth)'(out_h_q) * (2*bitwidth)'(in_w_q);
  assign fit_w   = xw <= xh;
  assign fit_n   = fit_w ? out_w_q : out_h_q;
  assign fit_d   = fit_w ? in_w_q : in_h_q;
  assign h_num_d = mode_q == MODE_STRETCH ? out_w_q : mode_q == MODE_FIT ? fit_n : ONE;
  assign h_den_d = mode_q == MODE_STRETCH ? in_w_q : mode_q == MODE_FIT ? fit_d : ONE;
  assign v_num_d = mode_q == MODE_STRETCH ? out_h_q : mode_q == MODE_FIT ? fit_n : ONE;
  assign v_den_d = mode_q == MODE_STRETCH ? in_h_q : mode_q == MODE_FIT ? fit_d : ONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      in_w_q    <= '0;
      in_h_q    <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      applied_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      h_num_q   <= ONE;
      h_den_q   <= ONE;
      h_lim_q   <= '0;
      v_num_q   <= ONE;
      v_den_q   <= ONE;
      v_lim_q   <= '0;
    end else begin
      if (meas_chg) begin
        in_w_q <= in_width;
        in_h_q <= in_height;
      end
      mode_q  <= scale_mode;
      out_w_q <= out_width;
      out_h_q <= out_height;
      if (chg) cnt_q <= CW'(1);
      else if (in_valid && !stable) cnt_q <= cnt_q + CW'(1);
      // any change after a sequence has started leaves it unapplied, so it reruns once stable
      if (chg) applied_q <= 1'b0;
      else if (start) applied_q <= 1'b1;
      error_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= H_REQ;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            h_num_q <= h_num_d;
            h_den_q <= h_den_d;
            h_lim_q <= in_w_q;
            v_num_q <= v_num_d;
            v_den_q <= v_den_d;
            v_lim_q <= in_h_q;
          end else if (!stable) valid_q <= 1'b0;
        H_REQ: state_q <= H_WAIT;
        H_WAIT:
          if (h_done) state_q <= V_REQ;
          else if (h_to) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        V_REQ: state_q <= V_WAIT;
        V_WAIT:
          if (v_done) state_q <= CENTRE;
          else if (v_to) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        CENTRE: state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  scaler_axis_req #(.bitwidth(bitwidth), .TIMEOUT(TIMEOUT)) u_h (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (state_q == H_REQ),
    .calc_i        (state_q == CENTRE),
    .ready_i       (h_ready),
    .limit_out_i   (h_limit_out),
    .out_i         (out_w_q),
    .newfraction_o (h_newfraction),
    .done_o        (h_done),
    .timeout_o     (h_to),
    .centre_o      (h_centre_offset)
  );
  scaler_axis_req #(.bitwidth(bitwidth), .TIMEOUT(TIMEOUT)) u_v (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (state_q == V_REQ),
    .calc_i        (state_q == CENTRE),
    .ready_i       (v_ready),
    .limit_out_i   (v_limit_out),
    .out_i         (out_h_q),
    .newfraction_o (v_newfraction),
    .done_o        (v_done),
    .timeout_o     (v_to),
    .centre_o      (v_centre_offset)
  );
  assign h_num     = h_num_q;
  assign h_den     = h_den_q;
  assign h_limit   = h_lim_q;
  assign v_num     = v_num_q;
  assign v_den     = v_den_q;
  assign v_limit   = v_lim_q;
  assign cfg_busy  = busy_q;
  assign cfg_valid = valid_q;
  assign cfg_error = error_q;
endmodule

// File: doc/scaler_ctrl.md
# scaler_ctrl

Configuration sequencer for the scandoubler's horizontal and vertical `frac_interp` instances. It watches the per-frame measured source resolution and waits until the resolution has been stable for a programmable number of frames. It then derives num/den/limit for each axis from the selected scale mode and the target output size. Finally it issues the `newfraction` handshakes H first, then V, and computes the centring offsets from the returned `limit_out`. It sits between the video-mode detector and the two interpolators.

## Interface
Parameters:
- `bitwidth`, 10: width of all pixel/line counts; matches the interpolators.
- `STABLE_FRAMES`, 2: number of consecutive identical measurements required before sequencing.
- `TIMEOUT`, 64: maximum cycles to wait for an interpolator `ready`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  one-cycle pulse at end of frame; `in_width`/`in_height` are valid on that cycle.
- `in_width`, `in_height`  in  bitwidth  measured source active size.
- `out_width`, `out_height`  in  bitwidth  target output size; quasi-static.
- `scale_mode`  in  2  0=off (1:1), 1=fit (aspect-preserving), 2=stretch, 3=reserved (treated as off).
- `h_num`, `h_den`, `h_limit`  out  bitwidth  horizontal interpolator configuration.
- `h_newfraction`  out  1  one-cycle request pulse.
- `h_ready`  in  1  completion from the interpolator; may be only one cycle wide.
- `h_limit_out`  in  bitwidth  anticipated output span.
- `h_centre_offset`  out  bitwidth  horizontal centring offset.
- `v_*`  same set for the vertical axis.
- `cfg_busy`  out  1  high from leaving STABLE until DONE.
- `cfg_valid`  out  1  high while the presented offsets match the current configuration.
- `cfg_error`  out  1  one-cycle pulse on timeout.

## Operation
- Reset values: all `*_num`/`*_den` = 1, `*_limit` = 0, `*_newfraction` = 0, `*_centre_offset` = 0, `cfg_busy` = 0, `cfg_valid` = 0, `cfg_error` = 0, state = IDLE, stable count = 0.
- Stability tracking:
  - On each `in_valid`, compare against the last latched measurement.
  - If equal, increment the saturating count; otherwise latch the new values and set the count to 1.
  - `scale_mode`, `out_width` or `out_height` changing also resets the count to 1.
- State machine:
  - IDLE: go to H_REQ when count ≥ STABLE_FRAMES and (config not yet applied or pending flag set). Widths of 0 never start a sequence.
  - H_REQ: drive `h_*`, pulse `h_newfraction` one cycle, then go to H_WAIT.
  - H_WAIT: latch `h_ready`/`h_limit_out`, then go to V_REQ. If the wait exceeds TIMEOUT cycles, pulse `cfg_error` and go to IDLE with `cfg_valid` = 0.
  - V_REQ / V_WAIT: same as H_REQ / H_WAIT for the vertical axis.
  - CENTRE: compute both offsets (1 cycle), then go to DONE.
  - DONE: set `cfg_valid`, clear `cfg_busy`, clear pending, return to IDLE.
- Per-axis arithmetic (num = output size, den = input size, limit = input size):
  - Off: num = den = 1.
  - Stretch: each axis uses its own out/in pair.
  - Fit: compare the 2·bitwidth cross products `out_width*in_height` and `out_height*in_width`.
    - If the first is ≤ the second (width-limited), both axes use num = `out_width`, den = `in_width`.
    - Otherwise both axes use num = `out_height`, den = `in_height`.
- Centre offset = (out − limit_out) >> 1 when limit_out < out, else 0. Width is bitwidth, truncating.
- A measurement or mode change while `cfg_busy` sets pending; the current sequence completes, then the sequence reruns with the latest values.
- A stability loss while IDLE with `cfg_valid` = 1 clears `cfg_valid`.

## Timing
- `*_num`/`*_den`/`*_limit` settle one cycle before the request pulse and are held until the matching ready is latched.
- `*_newfraction` is exactly one cycle; H and V requests never overlap.
- `*_ready` is captured on the cycle it is high; a ready outside the matching WAIT state is ignored.
- Latency from the qualifying `in_valid` to `cfg_valid` = 3 + H divide latency + V divide latency + 2 cycles.
- `reset_n` low at any point (including mid-WAIT) forces reset values asynchronously. There is no pending request after release.

## Structure
- Shared package `scaler_pkg`: the `scale_mode` encodings (OFF, FIT, STRETCH) and the state enum.
- One sub-module, `scaler_axis_req`, instantiated twice. It handles request pulse, ready latch, timeout counter and centre-offset calculation for one axis.
- Cross-multiply and mode selection stay in the top level.

## Test plan
- Stretch, 320×240 → 640×480, two identical `in_valid`s: `h_num`=640, `h_den`=320, `h_newfraction` pulses; model returns `limit_out` 640/480 → both offsets 0, `cfg_valid`=1.
- Fit, 320×200 → 640×480: 128000 ≤ 153600, so both axes get num 640 / den 320; `v_limit_out`=400 → `v_centre_offset`=40, `h_centre_offset`=0.
- Alternating 320×240 / 256×240 measurements: no `newfraction` ever issued, `cfg_valid` stays 0.
- Model withholds `h_ready`: `cfg_error` pulses after 64 cycles, no `v_newfraction`, `cfg_valid`=0.
- Mode changed during V_WAIT: after DONE, a second H/V sequence runs with the new values.
- `reset_n` asserted during H_WAIT: all outputs return to reset values immediately; a ready arriving after release is ignored.
